// File: rtl/file_dump_uart.sv
// rtl/file_dump_uart.sv - byte FIFO feeding an 8N1 UART transmitter, raw or hex-dump formatted
// Bytes are buffered on in_en and drained one character at a time; HEX mode expands each byte.
module file_dump_uart #(
  parameter int    CLK_DIV        = 868,
  parameter int    FIFO_AW        = 10,
  parameter string MODE           = "RAW",
  parameter int    BYTES_PER_LINE = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_en,
  input  logic [7:0]         in_byte,
  output logic               o_uart_tx,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               busy,
  output logic [31:0]        byte_count
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam bit                 HEX_MODE = (MODE == "HEX");
  localparam logic [15:0]        DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]         BPL_LAST = 8'(BYTES_PER_LINE - 1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic [1:0] {PH_HI, PH_LO, PH_SEP, PH_LF} hex_phase_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [7:0]         rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_ok;
  logic               pop;

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic [15:0]        div_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               bit_end;
  logic               char_pending;
  logic               load;
  logic               line_val;
  logic               tx_active;

  hex_phase_t         hex_phase;
  hex_phase_t         phase_nxt;
  logic [7:0]         line_cnt;
  logic [7:0]         line_nxt;
  logic [3:0]         hold_lo;
  logic [7:0]         next_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Level MSB is set only at exactly DEPTH entries, so it doubles as the full flag.
  assign fifo_full  = fifo_level[FIFO_AW];
  assign fifo_empty = (fifo_level == '0);
  assign wr_ok      = in_en && !fifo_full;
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= in_byte;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        byte_count <= byte_count + 32'd1;
      end
      if (in_en && fifo_full) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A HEX byte owns the line until its separator is out, so mid-byte phases count as pending.
  assign char_pending = !fifo_empty || (HEX_MODE && hex_phase != PH_HI);
  assign bit_end      = (div_cnt == DIV_LAST);
  assign load         = char_pending && ((state == IDLE) || (state == STOP && bit_end));

  always_comb begin
    next_char = rd_data;
    phase_nxt = hex_phase;
    line_nxt  = line_cnt;
    pop       = 1'b0;
    if (!HEX_MODE) begin
      pop = load;
    end else begin
      case (hex_phase)
        PH_HI: begin
          next_char = hex_ascii(rd_data[7:4]);
          phase_nxt = PH_LO;
          pop       = load;
        end
        PH_LO: begin
          next_char = hex_ascii(hold_lo);
          phase_nxt = PH_SEP;
        end
        PH_SEP: begin
          if (line_cnt == BPL_LAST) begin
            next_char = 8'h0D;
            phase_nxt = PH_LF;
            line_nxt  = 8'd0;
          end else begin
            next_char = 8'h20;
            phase_nxt = PH_HI;
            line_nxt  = line_cnt + 8'd1;
          end
        end
        default: begin
          next_char = 8'h0A;
          phase_nxt = PH_HI;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (char_pending) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      default: if (bit_end) state_nxt = char_pending ? START : IDLE;
    endcase
  end

  always_comb begin
    line_val = 1'b1;
    case (state)
      START:   line_val = 1'b0;
      DATA:    line_val = shreg[bit_idx];
      default: line_val = 1'b1;
    endcase
  end

  // Line is registered, so it trails the state by one cycle; tx_active covers that lag in busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_uart_tx <= 1'b1;
      tx_active <= 1'b0;
      div_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      hex_phase <= PH_HI;
      line_cnt  <= '0;
      hold_lo   <= '0;
    end else begin
      o_uart_tx <= line_val;
      tx_active <= (state != IDLE);
      if (state == IDLE || bit_end) div_cnt <= '0;
      else                          div_cnt <= div_cnt + 16'd1;
      if (state != DATA) bit_idx <= '0;
      else if (bit_end)  bit_idx <= bit_idx + 3'd1;
      if (load) begin
        shreg     <= next_char;
        hex_phase <= phase_nxt;
        line_cnt  <= line_nxt;
      end
      if (pop) hold_lo <= rd_data[3:0];
    end
  end

  assign busy = !fifo_empty || (state != IDLE) || tx_active;

endmodule

// File: tb/tb_file_dump_uart.sv
// tb/tb_file_dump_uart.sv - directed self-checking bench for file_dump_uart
// Three instances: RAW small FIFO, HEX two bytes per line, RAW deep FIFO for the burst.
module tb_file_dump_uart;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  in_byte;
  logic        raw_en, hex_en, big_en;
  logic        raw_tx, hex_tx, big_tx;
  logic [2:0]  raw_level, hex_level;
  logic [10:0] big_level;
  logic        raw_ovf, hex_ovf, big_ovf;
  logic        raw_busy, hex_busy, big_busy;
  logic [31:0] raw_cnt, hex_cnt, big_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] rxq_raw[$];
  logic [7:0] rxq_hex[$];
  logic [7:0] rxq_big[$];
  int         rxt_raw[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  file_dump_uart #(.CLK_DIV(4), .FIFO_AW(2), .MODE("RAW"), .BYTES_PER_LINE(16)) u_raw (
    .clk(clk), .rstn(rstn), .in_en(raw_en), .in_byte(in_byte), .o_uart_tx(raw_tx),
    .fifo_level(raw_level), .overflow(raw_ovf), .busy(raw_busy), .byte_count(raw_cnt));

  file_dump_uart #(.CLK_DIV(4), .FIFO_AW(2), .MODE("HEX"), .BYTES_PER_LINE(2)) u_hex (
    .clk(clk), .rstn(rstn), .in_en(hex_en), .in_byte(in_byte), .o_uart_tx(hex_tx),
    .fifo_level(hex_level), .overflow(hex_ovf), .busy(hex_busy), .byte_count(hex_cnt));

  file_dump_uart #(.CLK_DIV(2), .FIFO_AW(10), .MODE("RAW"), .BYTES_PER_LINE(16)) u_big (
    .clk(clk), .rstn(rstn), .in_en(big_en), .in_byte(in_byte), .o_uart_tx(big_tx),
    .fifo_level(big_level), .overflow(big_ovf), .busy(big_busy), .byte_count(big_cnt));

  function automatic logic line_of(input int which);
    case (which)
      0:       return raw_tx;
      1:       return hex_tx;
      default: return big_tx;
    endcase
  endfunction

  // Called on the first low sample of a start bit; samples each bit mid-cell.
  task automatic rx_frame(input int which, input int div, output logic [7:0] d);
    repeat (div / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      d[i] = line_of(which);
    end
    repeat (div) @(negedge clk);
  endtask

  always begin : mon_raw
    logic [7:0] d;
    @(negedge clk);
    if (rstn === 1'b1 && raw_tx === 1'b0) begin
      rxt_raw.push_back(cyc);
      rx_frame(0, 4, d);
      rxq_raw.push_back(d);
    end
  end

  always begin : mon_hex
    logic [7:0] d;
    @(negedge clk);
    if (rstn === 1'b1 && hex_tx === 1'b0) begin
      rx_frame(1, 4, d);
      rxq_hex.push_back(d);
    end
  end

  always begin : mon_big
    logic [7:0] d;
    @(negedge clk);
    if (rstn === 1'b1 && big_tx === 1'b0) begin
      rx_frame(2, 2, d);
      rxq_big.push_back(d);
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (raw_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", raw_tx); end
    total++; if (raw_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", raw_level); end
    total++; if (raw_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", raw_ovf); end
    total++; if (raw_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", raw_busy); end
    total++; if (raw_cnt !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", raw_cnt); end
    total++; if (hex_tx !== 1'b1) begin bad++; $display("FAIL reset_hex_tx: got %b want 1", hex_tx); end
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (raw_tx !== 1'b1) begin bad++; $display("FAIL idle_tx: got %b want 1", raw_tx); end
  endtask

  task automatic test_single();
    logic [9:0] frame;
    frame = {1'b1, 8'h41, 1'b0};
    rxq_raw.delete();
    in_byte = 8'h41; raw_en = 1'b1;
    @(posedge clk); #1;
    raw_en = 1'b0;
    @(posedge clk); #1;
    total++; if (raw_tx !== 1'b1) begin bad++; $display("FAIL single_early: got %b want 1", raw_tx); end
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      total++;
      if (raw_tx !== frame[c / 4]) begin
        bad++; $display("FAIL single_bit c=%0d: got %b want %b", c, raw_tx, frame[c / 4]);
      end
    end
    total++; if (raw_busy !== 1'b1) begin bad++; $display("FAIL single_busy_stop: got %b want 1", raw_busy); end
    @(posedge clk); #1;
    total++; if (raw_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", raw_busy); end
    total++; if (raw_cnt !== 32'd1) begin bad++; $display("FAIL single_count: got %0d want 1", raw_cnt); end
    total++;
    if (rxq_raw.size() != 1 || rxq_raw[0] !== 8'h41) begin
      bad++; $display("FAIL single_rx: got %0d bytes want one 0x41", rxq_raw.size());
    end
  endtask

  task automatic test_overflow();
    int k;
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    rxq_raw.delete(); rxt_raw.delete();
    for (int i = 0; i < 6; i++) begin
      in_byte = 8'(i); raw_en = 1'b1;
      @(posedge clk); #1;
    end
    raw_en = 1'b0;
    total++; if (raw_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", raw_ovf); end
    total++; if (raw_cnt !== 32'd5) begin bad++; $display("FAIL ovf_count: got %0d want 5", raw_cnt); end
    total++; if (raw_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", raw_level); end
    k = 0;
    while (raw_busy === 1'b1 && k < 400) begin @(posedge clk); #1; k++; end
    total++; if (k >= 400) begin bad++; $display("FAIL ovf_drain: busy still %b want 0", raw_busy); end
    total++;
    if (rxq_raw.size() != 5) begin
      bad++; $display("FAIL ovf_frames: got %0d want 5", rxq_raw.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (rxq_raw[i] !== 8'(i)) begin bad++; $display("FAIL ovf_data[%0d]: got %0h want %0h", i, rxq_raw[i], i); end
      end
      for (int i = 1; i < 5; i++) begin
        total++;
        if (rxt_raw[i] - rxt_raw[i-1] != 40) begin
          bad++; $display("FAIL ovf_gap[%0d]: got %0d want 40", i, rxt_raw[i] - rxt_raw[i-1]);
        end
      end
    end
    total++; if (raw_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", raw_ovf); end
  endtask

  task automatic test_simul();
    logic [7:0] exp_q[$];
    int t, k;
    rxq_raw.delete();
    in_byte = 8'hB0; raw_en = 1'b1; exp_q.push_back(8'hB0);
    @(posedge clk); #1;
    raw_en = 1'b0;
    @(posedge clk); #1;
    in_byte = 8'hB1; raw_en = 1'b1; exp_q.push_back(8'hB1);
    @(posedge clk); #1;
    in_byte = 8'hB2; exp_q.push_back(8'hB2);
    @(posedge clk); #1;
    raw_en = 1'b0;
    total++; if (raw_level !== 3'd2) begin bad++; $display("FAIL simul_setup: got %0d want 2", raw_level); end
    t = 3;
    for (int i = 0; i < 20; i++) begin
      int tgt;
      tgt = 41 + 40 * i;
      repeat (tgt - 1 - t) @(posedge clk);
      #1;
      in_byte = 8'(8'hC0 + i); raw_en = 1'b1; exp_q.push_back(8'(8'hC0 + i));
      @(posedge clk); #1;
      raw_en = 1'b0;
      total++;
      if (raw_level !== 3'd2) begin bad++; $display("FAIL simul_level[%0d]: got %0d want 2", i, raw_level); end
      t = tgt;
    end
    k = 0;
    while (raw_busy === 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
    total++; if (k >= 1000) begin bad++; $display("FAIL simul_drain: busy still %b want 0", raw_busy); end
    total++;
    if (rxq_raw.size() != 23) begin
      bad++; $display("FAIL simul_frames: got %0d want 23", rxq_raw.size());
    end else begin
      for (int i = 0; i < 23; i++) begin
        total++;
        if (rxq_raw[i] !== exp_q[i]) begin bad++; $display("FAIL simul_data[%0d]: got %0h want %0h", i, rxq_raw[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int zeros, k;
    rxq_raw.delete();
    in_byte = 8'h11; raw_en = 1'b1;
    @(posedge clk); #1;
    in_byte = 8'h00;
    @(posedge clk); #1;
    in_byte = 8'h22;
    @(posedge clk); #1;
    raw_en = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    total++; if (raw_tx !== 1'b0) begin bad++; $display("FAIL mid_predata: got %b want 0", raw_tx); end
    total++; if (raw_ovf !== 1'b1) begin bad++; $display("FAIL mid_ovf_before: got %b want 1", raw_ovf); end
    rstn = 1'b0;
    #1;
    total++; if (raw_tx !== 1'b1) begin bad++; $display("FAIL mid_tx: got %b want 1", raw_tx); end
    total++; if (raw_level !== 3'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", raw_level); end
    total++; if (raw_ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", raw_ovf); end
    total++; if (raw_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", raw_busy); end
    total++; if (raw_cnt !== 32'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", raw_cnt); end
    @(negedge clk) rstn = 1'b1;
    repeat (60) @(posedge clk);
    rxq_raw.delete();
    zeros = 0;
    repeat (60) begin @(posedge clk); #1; if (raw_tx !== 1'b1) zeros++; end
    total++; if (zeros != 0) begin bad++; $display("FAIL mid_quiet: got %0d low cycles want 0", zeros); end
    total++; if (rxq_raw.size() != 0) begin bad++; $display("FAIL mid_noframes: got %0d want 0", rxq_raw.size()); end
    in_byte = 8'h5A; raw_en = 1'b1;
    @(posedge clk); #1;
    raw_en = 1'b0;
    @(posedge clk); #1;
    total++; if (raw_tx !== 1'b1) begin bad++; $display("FAIL mid_lat1: got %b want 1", raw_tx); end
    @(posedge clk); #1;
    total++; if (raw_tx !== 1'b0) begin bad++; $display("FAIL mid_lat2: got %b want 0", raw_tx); end
    k = 0;
    while (raw_busy === 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
    total++;
    if (rxq_raw.size() != 1 || rxq_raw[0] !== 8'h5A) begin
      bad++; $display("FAIL mid_newbyte: got %0d bytes want one 0x5A", rxq_raw.size());
    end
  endtask

  task automatic test_hex();
    logic [7:0] exp_a[10];
    logic [7:0] exp_b[4];
    int k;
    exp_a = '{8'h33, 8'h43, 8'h20, 8'h41, 8'h35, 8'h0D, 8'h0A, 8'h30, 8'h46, 8'h20};
    exp_b = '{8'h37, 8'h45, 8'h0D, 8'h0A};
    rxq_hex.delete();
    in_byte = 8'h3C; hex_en = 1'b1;
    @(posedge clk); #1;
    in_byte = 8'hA5;
    @(posedge clk); #1;
    in_byte = 8'h0F;
    @(posedge clk); #1;
    hex_en = 1'b0;
    total++; if (hex_tx !== 1'b0) begin bad++; $display("FAIL hex_lat: got %b want 0", hex_tx); end
    k = 0;
    while (hex_busy === 1'b1 && k < 800) begin @(posedge clk); #1; k++; end
    total++; if (k >= 800) begin bad++; $display("FAIL hex_drain: busy still %b want 0", hex_busy); end
    total++;
    if (rxq_hex.size() != 10) begin
      bad++; $display("FAIL hex_chars: got %0d want 10", rxq_hex.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (rxq_hex[i] !== exp_a[i]) begin bad++; $display("FAIL hex_a[%0d]: got %0h want %0h", i, rxq_hex[i], exp_a[i]); end
      end
    end
    rxq_hex.delete();
    in_byte = 8'h7E; hex_en = 1'b1;
    @(posedge clk); #1;
    hex_en = 1'b0;
    k = 0;
    while (hex_busy === 1'b1 && k < 400) begin @(posedge clk); #1; k++; end
    total++;
    if (rxq_hex.size() != 4) begin
      bad++; $display("FAIL hex_wrap_chars: got %0d want 4", rxq_hex.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rxq_hex[i] !== exp_b[i]) begin bad++; $display("FAIL hex_b[%0d]: got %0h want %0h", i, rxq_hex[i], exp_b[i]); end
      end
    end
    total++; if (hex_cnt !== 32'd4) begin bad++; $display("FAIL hex_count: got %0d want 4", hex_cnt); end
  endtask

  task automatic test_back_to_back();
    int k, errs, first;
    rxq_big.delete();
    for (int i = 0; i < 1024; i++) begin
      in_byte = 8'(i * 7 + 3); big_en = 1'b1;
      @(posedge clk); #1;
    end
    big_en = 1'b0;
    total++; if (big_level !== 11'd972) begin bad++; $display("FAIL burst_level: got %0d want 972", big_level); end
    total++; if (big_ovf !== 1'b0) begin bad++; $display("FAIL burst_ovf: got %b want 0", big_ovf); end
    total++; if (big_cnt !== 32'd1024) begin bad++; $display("FAIL burst_count: got %0d want 1024", big_cnt); end
    k = 0;
    while (big_busy === 1'b1 && k < 25000) begin @(posedge clk); #1; k++; end
    total++; if (k >= 25000) begin bad++; $display("FAIL burst_drain: busy still %b want 0", big_busy); end
    total++;
    if (rxq_big.size() != 1024) begin
      bad++; $display("FAIL burst_frames: got %0d want 1024", rxq_big.size());
    end else begin
      errs = 0; first = -1;
      for (int i = 0; i < 1024; i++) begin
        if (rxq_big[i] !== 8'(i * 7 + 3)) begin errs++; if (first < 0) first = i; end
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL burst_data: got %0d wrong bytes (first at %0d) want 0", errs, first); end
    end
  endtask

  initial begin
    rstn = 1'b0; in_byte = 8'h00;
    raw_en = 1'b0; hex_en = 1'b0; big_en = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_simul();
    test_reset_mid();
    test_hex();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
